// File: rtl/invader_field.sv
// invader_field: invader formation bitmap, left/right march with descent, and bullet collision.
// Optional feature: define INVADER_SPEEDUP_EN to halve the march period once few invaders remain.
module invader_field #(
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned MARCH_DIV = 8
) (
  input  logic                 clk_36MHz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 bullet_flying,
  input  logic [4:0]           bullet_x,
  input  logic [3:0]           bullet_y,
  output logic                 hit,
  output logic [ROWS*COLS-1:0] alive,
  output logic [4:0]           field_x,
  output logic [3:0]           field_y,
  output logic                 wave_clear,
  output logic                 landed
);
  localparam int unsigned NINV  = ROWS * COLS;
  localparam int unsigned IDX_W = $clog2(NINV);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(MARCH_DIV);
  localparam logic [4:0] X_RIGHT = 5'(31 - 2 * (COLS - 1));
  localparam logic [3:0] Y_LAND  = 4'(15 - (ROWS - 1));
  localparam logic [4:0] COLS_L  = 5'(COLS);
  localparam logic [4:0] ROWS_L  = 5'(ROWS);

  typedef enum logic [1:0] {MARCH_R, MARCH_L, CLEARED, LANDED} state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, r_thr, w_thr_nx, w_thr_wrap;
  logic [4:0]        r_field_x, w_fx_nx;
  logic [3:0]        r_field_y, w_fy_nx;
  logic [NINV-1:0]   r_alive, w_alive_nx, w_mask;
  logic              r_hit, w_hit_nx;
  logic              w_march, w_x_ok, w_y_ok, w_coll;
  logic signed [5:0] w_dx, w_dy;
  logic [IDX_W-1:0]  w_idx;

  // Bullet position relative to invader (0,0); in-range only for non-negative even dx and small dy
  assign w_dx   = $signed({1'b0, bullet_x}) - $signed({1'b0, r_field_x});
  assign w_dy   = $signed({2'b0, bullet_y}) - $signed({2'b0, r_field_y});
  assign w_x_ok = !w_dx[5] && !w_dx[0] && ({1'b0, w_dx[4:1]} < COLS_L);
  assign w_y_ok = !w_dy[5] && (w_dy[4:0] < ROWS_L);
  assign w_idx  = IDX_W'(w_dy[4:0]) * IDX_W'(COLS) + IDX_W'(w_dx[4:1]);
  assign w_mask = NINV'(1) << w_idx;
  assign w_march = (r_state == MARCH_R) || (r_state == MARCH_L);
  assign w_coll  = w_march && bullet_flying && w_x_ok && w_y_ok &&
                   (|(r_alive & w_mask)) && !r_hit;

`ifdef INVADER_SPEEDUP_EN
  localparam logic [CNT_W-1:0] DIV_FAST = (MARCH_DIV / 2 == 0) ? CNT_W'(1) : CNT_W'(MARCH_DIV / 2);
  localparam logic [IDX_W:0]   POP_FAST = (IDX_W + 1)'(NINV / 4);
  logic [IDX_W:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NINV); i++) w_pop = w_pop + (IDX_W + 1)'(r_alive[i]);
  end
  assign w_thr_wrap = (w_pop <= POP_FAST) ? DIV_FAST : DIV_FULL;
`else
  assign w_thr_wrap = DIV_FULL;
`endif

  // Next-state: collision, step counter and march/descend/landing
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_thr_nx   = r_thr;
    w_fx_nx    = r_field_x;
    w_fy_nx    = r_field_y;
    w_alive_nx = r_alive;
    w_hit_nx   = 1'b0;
    if (clear) begin
      w_state_nx = MARCH_R;
      w_cnt_nx   = '0;
      w_thr_nx   = DIV_FULL;
      w_fx_nx    = '0;
      w_fy_nx    = '0;
      w_alive_nx = '1;
    end else if (w_march) begin
      if (w_coll) begin
        w_alive_nx = r_alive & ~w_mask;
        w_hit_nx   = 1'b1;
      end
      if (r_alive == '0) begin
        w_state_nx = CLEARED;
      end else if (enable) begin
        if (r_cnt == r_thr - CNT_W'(1)) begin
          w_cnt_nx = '0;
          w_thr_nx = w_thr_wrap;
          if ((r_state == MARCH_R && r_field_x == X_RIGHT) ||
              (r_state == MARCH_L && r_field_x == 5'd0)) begin
            w_fy_nx = r_field_y + 4'd1;
            if (r_field_y + 4'd1 == Y_LAND) w_state_nx = LANDED;
            else w_state_nx = (r_state == MARCH_R) ? MARCH_L : MARCH_R;
          end else if (r_state == MARCH_R) begin
            w_fx_nx = r_field_x + 5'd1;
          end else begin
            w_fx_nx = r_field_x - 5'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      r_state   <= MARCH_R;
      r_cnt     <= '0;
      r_thr     <= DIV_FULL;
      r_field_x <= '0;
      r_field_y <= '0;
      r_alive   <= '1;
      r_hit     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_thr     <= w_thr_nx;
      r_field_x <= w_fx_nx;
      r_field_y <= w_fy_nx;
      r_alive   <= w_alive_nx;
      r_hit     <= w_hit_nx;
    end
  end

  assign hit        = r_hit;
  assign alive      = r_alive;
  assign field_x    = r_field_x;
  assign field_y    = r_field_y;
  assign wave_clear = (r_state == CLEARED);
  assign landed     = (r_state == LANDED);
endmodule

// File: tb/tb_invader_field.sv
// Self-checking bench for invader_field: directed scenarios plus randomized play against a formation model.
module tb_invader_field;
  logic        clk_36MHz;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        bullet_flying;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        hit;
  logic [31:0] alive;
  logic [4:0]  field_x;
  logic [3:0]  field_y;
  logic        wave_clear;
  logic        landed;

  invader_field #(.COLS(8), .ROWS(4), .MARCH_DIV(8)) dut (
    .clk_36MHz(clk_36MHz), .reset(reset), .enable(enable), .clear(clear),
    .bullet_flying(bullet_flying), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(hit), .alive(alive), .field_x(field_x), .field_y(field_y),
    .wave_clear(wave_clear), .landed(landed)
  );

  initial clk_36MHz = 1'b0;
  always #5 clk_36MHz = ~clk_36MHz;

  localparam int ST_MARCH = 0;
  localparam int ST_CLR   = 1;
  localparam int ST_LAND  = 2;

  int n_chk = 0;
  int n_err = 0;

  // Formation model: positions as integers, direction as +1/-1
  bit [31:0] m_alive;
  int        m_fx, m_fy, m_dir, m_st, m_cnt, m_thr;
  bit        m_hit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_alive = '1; m_fx = 0; m_fy = 0; m_dir = 1;
    m_st = ST_MARCH; m_cnt = 0; m_thr = 8; m_hit = 0;
  endfunction

  function automatic void m_tick(input bit en, input bit clr, input bit bf,
                                 input logic [4:0] bx, input logic [3:0] by);
    int kill;
    kill = -1;
    if (clr) begin
      m_reset();
      return;
    end
    if (m_st != ST_MARCH) begin
      m_hit = 0;
      return;
    end
    if (bf && !m_hit)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++)
          if (m_alive[r*8+c] && int'(bx) == m_fx + 2*c && int'(by) == m_fy + r) kill = r*8 + c;
    if (m_alive == 0) begin
      m_st = ST_CLR;
    end else if (en) begin
      if (m_cnt == m_thr - 1) begin
        m_cnt = 0;
`ifdef INVADER_SPEEDUP_EN
        m_thr = ($countones(m_alive) <= 8) ? 4 : 8;
`endif
        if ((m_dir > 0 && m_fx + 14 == 31) || (m_dir < 0 && m_fx == 0)) begin
          m_fy++;
          if (m_fy + 3 == 15) m_st = ST_LAND;
          else m_dir = -m_dir;
        end else begin
          m_fx += m_dir;
        end
      end else begin
        m_cnt++;
      end
    end
    if (kill >= 0) m_alive[kill] = 1'b0;
    m_hit = (kill >= 0);
  endfunction

  task automatic cyc(input bit en, input bit clr, input bit bf,
                     input logic [4:0] bx, input logic [3:0] by);
    enable = en; clear = clr; bullet_flying = bf; bullet_x = bx; bullet_y = by;
    m_tick(en, clr, bf, bx, by);
    @(posedge clk_36MHz);
    #1;
    chk("hit", 32'(hit), 32'(m_hit));
    chk("alive", alive, m_alive);
    chk("field_x", 32'(field_x), 32'(m_fx));
    chk("field_y", 32'(field_y), 32'(m_fy));
    chk("wave_clear", 32'(wave_clear), 32'(m_st == ST_CLR));
    chk("landed", 32'(landed), 32'(m_st == ST_LAND));
  endtask

  task automatic aim(input int idx, output logic [4:0] bx, output logic [3:0] by);
    bx = 5'(m_fx + 2 * (idx % 8));
    by = 4'(m_fy + idx / 8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_alive"}, alive, 32'hFFFF_FFFF);
    chk({tag, "_fx"}, 32'(field_x), 32'd0);
    chk({tag, "_fy"}, 32'(field_y), 32'd0);
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_wclr"}, 32'(wave_clear), 32'd0);
    chk({tag, "_land"}, 32'(landed), 32'd0);
  endtask

  initial begin
    logic [4:0] bx;
    logic [3:0] by;
    int         fx_hold, guard, nchg, en_cnt;
    int         chg_at[3];
    logic [4:0] prev_fx;

    reset = 1'b0; enable = 0; clear = 0; bullet_flying = 0; bullet_x = '0; bullet_y = '0;
    repeat (2) @(posedge clk_36MHz);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;
    m_reset();

    // Idle march: 8 enables -> one step right
    repeat (8) cyc(1, 0, 0, '0, '0);
    chk("idle_fx", 32'(field_x), 32'd1);
    chk("idle_fy", 32'(field_y), 32'd0);

    // Direct hit at (4,2) = invader row 2, col 2, bit 18
    cyc(0, 1, 0, '0, '0);
    cyc(0, 0, 1, 5'd4, 4'd2);
    chk("direct_hit", 32'(hit), 32'd1);
    chk("direct_bit18", 32'(alive[18]), 32'd0);
    repeat (3) begin
      cyc(0, 0, 1, 5'd4, 4'd2);
      chk("held_nohit", 32'(hit), 32'd0);
    end

    // Near misses
    cyc(0, 1, 0, '0, '0);
    cyc(0, 0, 1, 5'd5, 4'd2);
    chk("miss_odd", 32'(hit), 32'd0);
    cyc(0, 0, 1, 5'd16, 4'd0);
    chk("miss_col8", 32'(hit), 32'd0);
    cyc(0, 0, 1, 5'd4, 4'd4);
    chk("miss_row4", 32'(hit), 32'd0);
    chk("miss_alive", alive, 32'hFFFF_FFFF);

    // March edges, then on to landing
    cyc(0, 1, 0, '0, '0);
    repeat (136) cyc(1, 0, 0, '0, '0);
    chk("edge_r_fx", 32'(field_x), 32'd17);
    chk("edge_r_fy", 32'(field_y), 32'd0);
    repeat (8) cyc(1, 0, 0, '0, '0);
    chk("desc1_fx", 32'(field_x), 32'd17);
    chk("desc1_fy", 32'(field_y), 32'd1);
    repeat (136) cyc(1, 0, 0, '0, '0);
    chk("edge_l_fx", 32'(field_x), 32'd0);
    chk("edge_l_fy", 32'(field_y), 32'd1);
    repeat (8) cyc(1, 0, 0, '0, '0);
    chk("desc2_fx", 32'(field_x), 32'd0);
    chk("desc2_fy", 32'(field_y), 32'd2);
    guard = 0;
    while (m_st != ST_LAND && guard < 3000) begin
      cyc(1, 0, 0, '0, '0);
      guard++;
    end
    chk("landed_flag", 32'(landed), 32'd1);
    chk("landed_fy", 32'(field_y), 32'd12);
    fx_hold = int'(field_x);
    repeat (16) cyc(1, 0, 1, field_x, field_y);
    chk("landed_frozen_fx", 32'(field_x), 32'(fx_hold));
    chk("landed_frozen_fy", 32'(field_y), 32'd12);

    // Kill the whole wave
    cyc(0, 1, 0, '0, '0);
    chk_reset_vals("clear1");
    guard = 0;
    while (m_alive != 0 && guard < 200) begin
      for (int i = 0; i < 32; i++)
        if (m_alive[i]) begin
          aim(i, bx, by);
          break;
        end
      cyc(0, 0, 1, bx, by);
      chk("kill_hit", 32'(hit), 32'd1);
      cyc(0, 0, 0, '0, '0);
      guard++;
    end
    chk("wave_clear", 32'(wave_clear), 32'd1);
    chk("wave_alive", alive, 32'd0);
    cyc(1, 0, 0, '0, '0);
    cyc(0, 1, 0, '0, '0);
    chk_reset_vals("clear2");

    // March period after 24 kills
    for (int i = 0; i < 24; i++) begin
      aim(i, bx, by);
      cyc(0, 0, 1, bx, by);
      cyc(0, 0, 0, '0, '0);
    end
    nchg = 0; en_cnt = 0;
    prev_fx = field_x;
    for (int k = 0; k < 40; k++) begin
      cyc(1, 0, 0, '0, '0);
      en_cnt++;
      if (field_x != prev_fx && nchg < 3) begin
        chg_at[nchg] = en_cnt;
        nchg++;
      end
      prev_fx = field_x;
    end
    chk("speed_steps", 32'(nchg), 32'd3);
`ifdef INVADER_SPEEDUP_EN
    chk("speed_period", 32'(chg_at[2] - chg_at[1]), 32'd4);
`else
    chk("speed_period", 32'(chg_at[2] - chg_at[1]), 32'd8);
`endif

    // Randomized play
    cyc(0, 1, 0, '0, '0);
    for (int k = 0; k < 2500; k++) begin
      bit en, clr, bf;
      en  = ($urandom_range(1, 0) == 1);
      clr = ($urandom_range(299, 0) == 0);
      bf  = ($urandom_range(3, 0) != 0);
      if ($urandom_range(1, 0) == 1) begin
        aim(int'($urandom_range(31, 0)), bx, by);
      end else begin
        bx = 5'($urandom_range(31, 0));
        by = 4'($urandom_range(15, 0));
      end
      cyc(en, clr, bf, bx, by);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
